// File: rtl/jump_fetch_queue.sv
// jump_fetch_queue: N-wide instruction fetch front end with an issue queue.
//   Fetches FETCH_W contiguous words per cycle at PC. The first J in the
//   group redirects PC to its absolute target; the J and all younger slots
//   are squashed. Surviving {instr, pc} pairs go into a circular queue that
//   is read oldest-first by in-order issue.
// Optional build macro: NOP_DROP_EN -- NOP slots (before any J) are not
//   enqueued; survivors are compacted. PC advance is unaffected.
// Ports:
//   clk1        clock, rising edge
//   reset       asynchronous, active-low
//   imem_addr   word address of fetch slot 0 (registered PC)
//   imem_rdata  words PC..PC+FETCH_W-1, slot k at [32k+:32], same-cycle read
//   flush       external redirect; empties queue, PC <= flush_pc
//   flush_pc    redirect target
//   deq_take    number of head entries consumed this cycle
//   deq_valid   thermometer: bit k set when the k-th oldest entry exists
//   deq_instr   k-th oldest instruction, zero when not valid
//   deq_pc      k-th oldest PC, zero when not valid
//   q_count     current occupancy

// Per-slot decode: opcode classification and slot address.
module jfq_lane #(
  parameter int          ADDR_W  = 10,
  parameter int          LANE    = 0,
  parameter logic [5:0]  OPC_J   = 6'b100000,
  parameter logic [5:0]  OPC_NOP = 6'b111111
) (
  input  logic [5:0]        opc,
  input  logic [ADDR_W-1:0] base_pc,
  output logic              is_j,
  output logic              is_nop,
  output logic [ADDR_W-1:0] slot_pc
);
  assign is_j    = (opc == OPC_J);
  assign is_nop  = (opc == OPC_NOP);
  // wraps modulo 2^ADDR_W at the top of memory
  assign slot_pc = base_pc + ADDR_W'(LANE);
endmodule

module jump_fetch_queue #(
  parameter int               FETCH_W  = 2,
  parameter int               QDEPTH   = 8,
  parameter int               ADDR_W   = 10,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter logic [5:0]       OPC_J    = 6'b100000,
  parameter logic [5:0]       OPC_NOP  = 6'b111111
) (
  input  logic                           clk1,
  input  logic                           reset,
  output logic [ADDR_W-1:0]              imem_addr,
  input  logic [FETCH_W*32-1:0]          imem_rdata,
  input  logic                           flush,
  input  logic [ADDR_W-1:0]              flush_pc,
  input  logic [$clog2(FETCH_W+1)-1:0]   deq_take,
  output logic [FETCH_W-1:0]             deq_valid,
  output logic [FETCH_W*32-1:0]          deq_instr,
  output logic [FETCH_W*ADDR_W-1:0]      deq_pc,
  output logic [$clog2(QDEPTH+1)-1:0]    q_count
);
  localparam int PW = $clog2(QDEPTH);
  localparam int CW = $clog2(QDEPTH+1);

`ifdef NOP_DROP_EN
  localparam bit DROP_NOP = 1'b1;
`else
  localparam bit DROP_NOP = 1'b0;
`endif

  logic [ADDR_W-1:0] pc;
  logic [PW-1:0]     head, tail;

  logic [31:0]       instr_q [QDEPTH];
  logic [ADDR_W-1:0] pc_q    [QDEPTH];

  logic [FETCH_W-1:0][31:0]       word;
  logic [FETCH_W-1:0][ADDR_W-1:0] slot_pc;
  logic [FETCH_W-1:0]             is_j, is_nop;

  assign word      = imem_rdata;
  assign imem_addr = pc;

  for (genvar k = 0; k < FETCH_W; k++) begin : g_lane
    jfq_lane #(
      .ADDR_W(ADDR_W), .LANE(k), .OPC_J(OPC_J), .OPC_NOP(OPC_NOP)
    ) u_lane (
      .opc    (word[k][31:26]),
      .base_pc(pc),
      .is_j   (is_j[k]),
      .is_nop (is_nop[k]),
      .slot_pc(slot_pc[k])
    );
  end

  // Group scan: keep slots older than the first J; each kept slot is
  // written at tail + (number of kept slots before it), which compacts
  // around dropped NOPs.
  logic                         j_found;
  logic [ADDR_W-1:0]            j_target;
  logic [FETCH_W-1:0]           keep;
  logic [FETCH_W-1:0][PW-1:0]   wr_addr;
  logic [CW-1:0]                enq_cnt;

  always_comb begin
    j_found  = 1'b0;
    j_target = '0;
    keep     = '0;
    enq_cnt  = '0;
    wr_addr  = '0;
    for (int k = 0; k < FETCH_W; k++) begin
      wr_addr[k] = tail + PW'(enq_cnt);
      if (!j_found) begin
        if (is_j[k]) begin
          j_found  = 1'b1;
          j_target = word[k][ADDR_W-1:0];
        end else if (!(DROP_NOP && is_nop[k])) begin
          keep[k] = 1'b1;
          enq_cnt = enq_cnt + CW'(1);
        end
      end
    end
  end

  // Fetch room is judged on occupancy before this cycle's dequeue.
  logic          fetch_ok;
  logic [CW-1:0] enq_eff, avail, take_eff;

  always_comb begin
    fetch_ok = (CW'(QDEPTH) - q_count) >= CW'(FETCH_W);
    enq_eff  = fetch_ok ? enq_cnt : '0;
    avail    = (q_count > CW'(FETCH_W)) ? CW'(FETCH_W) : q_count;
    // over-asking is clipped to what is actually visible
    take_eff = (CW'(deq_take) > avail) ? avail : CW'(deq_take);
  end

  always_ff @(posedge clk1 or negedge reset) begin
    if (!reset) begin
      pc      <= RESET_PC;
      head    <= '0;
      tail    <= '0;
      q_count <= '0;
    end else if (flush) begin
      pc      <= flush_pc;
      head    <= '0;
      tail    <= '0;
      q_count <= '0;
    end else begin
      head    <= head + PW'(take_eff);
      q_count <= q_count + enq_eff - take_eff;
      if (fetch_ok) begin
        tail <= tail + PW'(enq_cnt);
        pc   <= j_found ? j_target : pc + ADDR_W'(FETCH_W);
      end
    end
  end

  // Storage has no reset: q_count/head gate everything that is visible.
  always_ff @(posedge clk1) begin
    if (fetch_ok && !flush) begin
      for (int k = 0; k < FETCH_W; k++) begin
        if (keep[k]) begin
          instr_q[wr_addr[k]] <= word[k];
          pc_q[wr_addr[k]]    <= slot_pc[k];
        end
      end
    end
  end

  logic [FETCH_W-1:0][31:0]       rd_instr;
  logic [FETCH_W-1:0][ADDR_W-1:0] rd_pc;
  logic [PW-1:0]                  rd_addr;

  always_comb begin
    deq_valid = '0;
    rd_instr  = '0;
    rd_pc     = '0;
    rd_addr   = '0;
    for (int k = 0; k < FETCH_W; k++) begin
      rd_addr      = head + PW'(k);
      deq_valid[k] = q_count > CW'(k);
      if (deq_valid[k]) begin
        rd_instr[k] = instr_q[rd_addr];
        rd_pc[k]    = pc_q[rd_addr];
      end
    end
  end

  assign deq_instr = rd_instr;
  assign deq_pc    = rd_pc;

  always_ff @(posedge clk1) begin
    if (reset && !flush)
      assert (CW'(deq_take) <= avail);
  end

endmodule

// File: tb/tb_jump_fetch_queue.sv
// Directed bench for jump_fetch_queue (FETCH_W=2, QDEPTH=8, ADDR_W=10).
module tb_jump_fetch_queue;
  localparam int AW = 10;

`ifdef NOP_DROP_EN
  localparam bit DROP = 1'b1;
`else
  localparam bit DROP = 1'b0;
`endif

  logic          clk1 = 1'b0;
  logic          reset;
  logic [AW-1:0] imem_addr;
  logic [63:0]   imem_rdata;
  logic          flush;
  logic [AW-1:0] flush_pc;
  logic [1:0]    deq_take;
  logic [1:0]    deq_valid;
  logic [63:0]   deq_instr;
  logic [19:0]   deq_pc;
  logic [3:0]    q_count;

  logic [31:0] mem [1024];
  int n_assert = 0;
  int n_fail   = 0;
  int issued[$];

  jump_fetch_queue dut (
    .clk1(clk1), .reset(reset), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .flush(flush), .flush_pc(flush_pc), .deq_take(deq_take), .deq_valid(deq_valid),
    .deq_instr(deq_instr), .deq_pc(deq_pc), .q_count(q_count)
  );

  always #5 clk1 = ~clk1;

  always_comb begin
    imem_rdata = '0;
    for (int k = 0; k < 2; k++)
      imem_rdata[32*k +: 32] = mem[imem_addr + AW'(k)];
  end

  function automatic logic [31:0] add_w(input int a);
    return {6'h00, 26'(a)};
  endfunction

  localparam logic [31:0] NOP_W = {6'b111111, 26'd0};
  localparam logic [31:0] J10   = {6'b100000, 26'd10};
  localparam logic [31:0] J20   = {6'b100000, 26'd20};

  task automatic load_prog();
    for (int i = 0; i < 1024; i++) mem[i] = NOP_W;
    mem[0] = add_w(100); mem[1] = add_w(101); mem[2] = add_w(102);
    mem[3] = J10;
    for (int i = 14; i <= 17; i++) mem[i] = add_w(i);
    mem[20]   = J20;
    mem[1023] = add_w(1023);
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk1);
    #1;
  endtask

  task automatic pulse_reset();
    reset = 1'b0;
    #2;
    reset = 1'b1;
  endtask

  int exp_iss [7];
  int n;
  int hits;

  initial begin
    reset = 1'b0; flush = 1'b0; flush_pc = '0; deq_take = '0;
    load_prog();
    #3;
    chk("rst_count", q_count, 0);
    chk("rst_valid", deq_valid, 0);
    chk("rst_addr", imem_addr, 0);
    chk("rst_pc", deq_pc, 0);
    chk("rst_instr", deq_instr, 0);
    #4 reset = 1'b1;

    // program fetch, no dequeue
    tick();
    chk("t1_addr0", imem_addr, 2);
    chk("t1_cnt0", q_count, 2);
    chk("t1_valid0", deq_valid, 2'b11);
    chk("t1_pc0", deq_pc, {10'd1, 10'd0});
    chk("t1_instr0", deq_instr[31:0], add_w(100));
    tick();
    chk("t1_addr1", imem_addr, 10);
    chk("t1_cnt1", q_count, 3);
    tick();
    chk("t1_addr2", imem_addr, 12);
    chk("t1_cnt2", q_count, DROP ? 3 : 5);

    // asynchronous reset between edges
    #2 reset = 1'b0;
    #1;
    chk("ar_count", q_count, 0);
    chk("ar_valid", deq_valid, 0);
    chk("ar_addr", imem_addr, 0);
    chk("ar_pc", deq_pc, 0);
    #1 reset = 1'b1;

    // issue stream, taking every visible entry
    tick();
    for (int c = 0; c < 14; c++) begin
      n = deq_valid[1] ? 2 : (deq_valid[0] ? 1 : 0);
      for (int k = 0; k < n; k++) issued.push_back(int'(deq_pc[10*k +: 10]));
      deq_take = 2'(n);
      tick();
    end
    deq_take = '0;
    if (DROP) exp_iss = '{0, 1, 2, 14, 15, 16, 17};
    else      exp_iss = '{0, 1, 2, 10, 11, 12, 13};
    chk("iss_size", issued.size() >= 7, 1'b1);
    for (int k = 0; k < 7; k++)
      chk($sformatf("iss_%0d", k), (k < issued.size()) ? issued[k] : -1, exp_iss[k]);
    hits = 0;
    foreach (issued[i]) if (issued[i] == 3) hits++;
    chk("iss_no_j", hits, 0);

    // fill to full, hold, then drain two
    for (int i = 0; i < 1024; i++) mem[i] = add_w(i);
    pulse_reset();
    for (int c = 1; c <= 4; c++) begin
      tick();
      chk($sformatf("fill_cnt%0d", c), q_count, 2*c);
      chk($sformatf("fill_addr%0d", c), imem_addr, 2*c);
    end
    tick();
    chk("full_cnt", q_count, 8);
    chk("full_addr", imem_addr, 8);
    chk("full_pc", deq_pc, {10'd1, 10'd0});
    deq_take = 2'd2;
    tick();
    deq_take = 2'd0;
    chk("drain_cnt", q_count, 6);
    chk("drain_addr", imem_addr, 8);
    chk("drain_pc", deq_pc, {10'd3, 10'd2});
    tick();
    chk("refill_cnt", q_count, 8);
    chk("refill_addr", imem_addr, 10);
    chk("refill_instr", deq_instr[31:0], add_w(2));

    // flush in the cycle the J is fetched
    load_prog();
    pulse_reset();
    tick();
    chk("fl_pre_addr", imem_addr, 2);
    flush = 1'b1; flush_pc = 10'd40; deq_take = 2'd2;
    tick();
    flush = 1'b0; deq_take = 2'd0;
    chk("fl_cnt", q_count, 0);
    chk("fl_addr", imem_addr, 40);
    chk("fl_valid", deq_valid, 0);
    tick();
    chk("fl_next_addr", imem_addr, 42);
    chk("fl_next_cnt", q_count, DROP ? 0 : 2);
    if (!DROP) chk("fl_next_pc", deq_pc, {10'd41, 10'd40});

    // address wrap at top of memory
    flush = 1'b1; flush_pc = 10'd1023;
    tick();
    flush = 1'b0;
    chk("wr_addr0", imem_addr, 1023);
    tick();
    chk("wr_addr1", imem_addr, 1);
    chk("wr_cnt", q_count, 2);
    chk("wr_pc", deq_pc, {10'd0, 10'd1023});
    tick();
    chk("wr_addr2", imem_addr, 3);
    chk("wr_cnt2", q_count, 4);
    // J in slot 0: nothing enqueued
    tick();
    chk("j0_addr", imem_addr, 10);
    chk("j0_cnt", q_count, 4);

    // jump to self spins
    flush = 1'b1; flush_pc = 10'd20;
    tick();
    flush = 1'b0;
    tick();
    chk("spin_addr0", imem_addr, 20);
    chk("spin_cnt0", q_count, 0);
    tick();
    chk("spin_addr1", imem_addr, 20);
    chk("spin_valid", deq_valid, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
